// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module : dmem_port_arbiter_if
// Brief  : Signal bundle between the data-memory arbiter, its two requesters
//          (CPU data port, auxiliary reader/writer) and the single-port RAM.
//          master : arbiter view (drives grants, stall, read data, RAM side)
//          slave  : environment view (requesters and RAM)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // CPU data port
  logic                  cpu_access;
  logic                  cpu_wren;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic [DATA_WIDTH-1:0] cpu_q;
  logic                  cpu_stall;
  // Auxiliary requester
  logic                  aux_req;
  logic                  aux_wren;
  logic [ADDR_WIDTH-1:0] aux_addr;
  logic [DATA_WIDTH-1:0] aux_data;
  logic                  aux_gnt;
  logic [DATA_WIDTH-1:0] aux_q;
  logic                  aux_q_valid;
  // RAM side
  logic                  ram_wEn;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dataIn;
  logic [DATA_WIDTH-1:0] ram_dataOut;

  modport master (
    input  cpu_access, cpu_wren, cpu_addr, cpu_data,
    input  aux_req, aux_wren, aux_addr, aux_data,
    input  ram_dataOut,
    output cpu_q, cpu_stall, aux_gnt, aux_q, aux_q_valid,
    output ram_wEn, ram_addr, ram_dataIn
  );

  modport slave (
    output cpu_access, cpu_wren, cpu_addr, cpu_data,
    output aux_req, aux_wren, aux_addr, aux_data,
    output ram_dataOut,
    input  cpu_q, cpu_stall, aux_gnt, aux_q, aux_q_valid,
    input  ram_wEn, ram_addr, ram_dataIn
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Shares a single-port synchronous-read RAM between the CPU data port
//          (priority owner) and an auxiliary req/gnt requester. After MAX_WAIT
//          consecutive aux denials the CPU is stalled for one FORCE cycle so
//          the aux access is served.
// Ports  : clock       - processor clock, all state on rising edge
//          anti_reset  - asynchronous active-low reset
//          bus         - dmem_port_arbiter_if.master (CPU, aux and RAM signals)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  wire logic             clock,
  input  wire logic             anti_reset,
  dmem_port_arbiter_if.master   bus
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [7:0]            wait_cnt, wait_cnt_next;
  logic                  in_force;
  logic                  cpu_owns;
  logic                  aux_owns;
  logic                  aux_q_valid_r;
  logic                  cpu_hold_sel;
  logic [DATA_WIDTH-1:0] cpu_hold_reg;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  // Ownership and next-state. Everything is gated by anti_reset so the
  // handshake outputs and the RAM write enable are quiet while in reset.
  always_comb begin
    state_next    = state;
    wait_cnt_next = 8'd0;
    in_force      = (state == FORCE);
    cpu_owns      = 1'b0;
    aux_owns      = 1'b0;
    if (anti_reset) begin
      if (in_force) begin
        // CPU is frozen; aux gets the port if it is still asking.
        aux_owns   = bus.aux_req;
        state_next = NORMAL;
      end else begin
        cpu_owns = bus.cpu_access;
        aux_owns = bus.aux_req && !bus.cpu_access;
        if (bus.aux_req && !aux_owns) begin
          wait_cnt_next = wait_cnt + 8'd1;
          // This denial is the MAX_WAIT-th in a row: steal the next cycle.
          if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            state_next = FORCE;
          end
        end
      end
    end
  end

  // With no owner the RAM still sees the CPU address/data, write disabled.
  assign addr_sel = aux_owns ? bus.aux_addr : bus.cpu_addr;
  assign data_sel = aux_owns ? bus.aux_data : bus.cpu_data;

  assign bus.ram_addr    = addr_sel;
  assign bus.ram_dataIn  = data_sel;
  assign bus.ram_wEn     = (cpu_owns && bus.cpu_wren) || (aux_owns && bus.aux_wren);
  assign bus.cpu_stall   = anti_reset && in_force;
  assign bus.aux_gnt     = aux_owns;
  assign bus.aux_q       = bus.ram_dataOut;
  assign bus.aux_q_valid = aux_q_valid_r;
  // The CPU load issued just before FORCE returns during FORCE, but the CPU
  // only consumes it the cycle after; replay the captured word then.
  assign bus.cpu_q       = cpu_hold_sel ? cpu_hold_reg : bus.ram_dataOut;

  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      state         <= NORMAL;
      wait_cnt      <= 8'd0;
      aux_q_valid_r <= 1'b0;
      cpu_hold_sel  <= 1'b0;
      cpu_hold_reg  <= '0;
    end else begin
      state         <= state_next;
      wait_cnt      <= wait_cnt_next;
      aux_q_valid_r <= aux_owns && !bus.aux_wren;
      cpu_hold_sel  <= in_force;
      if (in_force) begin
        cpu_hold_reg <= bus.ram_dataOut;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port processor RAM (12-bit address, 32-bit data, synchronous read with 1-cycle latency) between two requesters: the CPU data port and an auxiliary requester, such as a VGA sprite/score reader.
- The CPU has priority. The aux requester uses a req/gnt handshake.
- A starvation counter forces a one-cycle CPU stall so aux is guaranteed service within MAX_WAIT+1 cycles.
- Sits between processor/RAM in the top-level wrapper, clocked by the 50 MHz processor clock.

Parameters:
ADDR_WIDTH, 12, RAM address width
DATA_WIDTH, 32, RAM data width
MAX_WAIT, 8, consecutive denied aux cycles before a forced slot (legal range 1..255)

Ports:
clock  in  1  processor clock; all state on rising edge
anti_reset  in  1  asynchronous active-low reset
cpu_access  in  1  CPU performs a load or store this cycle
cpu_wren  in  1  CPU store enable (qualified by cpu_access)
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_data  in  DATA_WIDTH  CPU store data
cpu_q  out  DATA_WIDTH  CPU load data (valid cycle after the access)
cpu_stall  out  1  CPU must freeze pipeline this cycle
aux_req  in  1  aux access request; aux holds addr/data/wren stable until gnt
aux_wren  in  1  aux write enable
aux_addr  in  ADDR_WIDTH  aux address
aux_data  in  DATA_WIDTH  aux write data
aux_gnt  out  1  aux owns RAM this cycle; access completes at this edge
aux_q  out  DATA_WIDTH  aux read data (direct from ram_dataOut)
aux_q_valid  out  1  registered pulse: aux_q valid (cycle after granted aux read)
ram_wEn  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_dataIn  out  DATA_WIDTH  RAM write data
ram_dataOut  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (anti_reset=0, async):
  - State=NORMAL, wait_cnt=0, aux_q_valid=0, cpu_hold_sel=0, cpu_hold_reg=0.
  - Combinational outputs under reset: cpu_stall=0, aux_gnt=0, ram_wEn=0.
- States: NORMAL, FORCE.
- Ownership in NORMAL (combinational):
  - cpu_access=1 → CPU owns the port.
  - else aux_req=1 → aux owns the port; aux_gnt=1.
  - else no owner: ram_wEn=0, ram_addr=cpu_addr, ram_dataIn=cpu_data.
- Ownership in FORCE:
  - cpu_stall=1.
  - aux owns the port if aux_req=1, with aux_gnt=1.
  - If aux_req=0, no owner and ram_wEn=0.
- RAM muxing:
  - ram_wEn = owner's wren AND owner valid.
  - ram_addr and ram_dataIn come from the owner.
- wait_cnt behaviour:
  - wait_cnt increments when aux_req=1 and aux_gnt=0 in NORMAL.
  - wait_cnt clears when aux_gnt=1, when aux_req=0, or on leaving FORCE.
- Transitions:
  - NORMAL → FORCE when aux_req=1, aux_gnt=0 and wait_cnt==MAX_WAIT-1; i.e. the MAX_WAIT-th consecutive denial.
  - FORCE → NORMAL unconditionally after one cycle.
- CPU read preservation:
  - The CPU access issued in the cycle before FORCE returns its data on ram_dataOut during the FORCE cycle.
  - In the FORCE cycle, cpu_hold_reg captures ram_dataOut and cpu_hold_sel is set to 1 for exactly the next cycle.
  - cpu_q = cpu_hold_sel ? cpu_hold_reg : ram_dataOut.
- aux_q_valid is set on the next edge iff aux_gnt=1 and aux_wren=0 in the current cycle.
- Aux writes produce no valid pulse.
- Simultaneous cpu_access and aux_req in NORMAL: CPU wins and aux waits.
- Aux write and CPU read of the same address in one cycle cannot occur, because only one owner is selected per cycle.
- aux_req dropped while waiting: the request is withdrawn, wait_cnt clears, and no grant is issued.
- Reset asserted mid-FORCE: return to NORMAL immediately and drop any pending valid/hold.

Test Plan:
- No CPU traffic; aux read at addr 0x010 holding 0xDEADBEEF → aux_gnt in same cycle, aux_q_valid=1 next cycle with aux_q=0xDEADBEEF, cpu_stall never asserted.
- cpu_access=1 continuously, cpu_wren=0, aux_req=1 at addr 0x020 (MAX_WAIT=8):
  - 8 denied cycles, then FORCE with cpu_stall=1 and aux_gnt=1 on the 9th cycle.
  - aux_q_valid follows; wait_cnt returns to 0.
- CPU load of 0x005 (=0x12345678) issued in the cycle before FORCE, aux read of 0x006 (=0xAAAA5555) in FORCE:
  - cpu_q=0x12345678 in the cycle after FORCE.
  - aux_q=0xAAAA5555 with aux_q_valid=1 in the same cycle.
- Simultaneous CPU store 0x111 to 0x030 and aux store 0x222 to 0x030 → CPU writes first, aux writes on first free cycle; final RAM[0x030]=0x222, no aux_q_valid pulse.
- aux_req held 5 cycles under CPU traffic, then dropped → no aux_gnt, wait_cnt=0, state stays NORMAL.
- anti_reset pulsed low during FORCE → cpu_stall=0, aux_gnt=0, aux_q_valid=0 asynchronously; after release, a normal aux read completes in 2 cycles.
